mac_out_packer: RTL

Downstream writeback stage for the `mac3` pipeline. It accepts signed accumulator results one per cycle and applies optional ReLU and saturating requantisation to a narrower width. It packs `PACK` results into one memory word and issues byte-lane-masked writes to output memory over a valid/ready handshake. A small FIFO decouples the MAC pipeline from memory stalls, and back-pressure is signalled on `in_ready`.

---
 rtl/mac_out_packer_pkg.sv | 24 ++
 rtl/mac_out_packer_if.sv | 29 ++
 rtl/mac_out_packer_word_fifo.sv | 61 ++++++
 rtl/mac_out_packer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mac_out_packer_pkg.sv
// Shared types and the ReLU/saturation helper for the MAC writeback packer.
package mac_out_packer_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

   // Optional ReLU, then clamp to the signed range of out_w bits; caller keeps the low out_w bits.
   function automatic logic signed [63:0] sat_relu(input logic signed [63:0] x,
                                                   input int unsigned out_w,
                                                   input logic relu_en);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] y;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      y = (relu_en && (x < 0)) ? 64'sd0 : x;
      if (y > hi) begin
         y = hi;
      end else if (y < lo) begin
         y = lo;
      end
      return y;
   endfunction

endpackage

// File: rtl/mac_out_packer_if.sv
// Sample-input and memory-write handshake bundle between the MAC pipeline, packer and memory.
interface mac_out_packer_if #(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned PACK       = 4,
   parameter int unsigned ADDR_WIDTH = 16
);

   logic                        in_valid;
   logic                        in_ready;
   logic [IN_WIDTH-1:0]         in_data;
   logic                        in_last;
   logic                        mem_valid;
   logic                        mem_ready;
   logic [ADDR_WIDTH-1:0]       mem_addr;
   logic [PACK*OUT_WIDTH-1:0]   mem_wdata;
   logic [PACK-1:0]             mem_wmask;

   modport master (
      output in_valid, in_data, in_last, mem_ready,
      input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wmask
   );

   modport slave (
      input  in_valid, in_data, in_last, mem_ready,
      output in_ready, mem_valid, mem_addr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/mac_out_packer_word_fifo.sv
// Shift-register FIFO: entry 0 is always the registered head, so no read mux sits after the flops.
module word_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  rdata_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CntW-1:0]   count_o
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [CntW-1:0]  count_q, count_d, wr_idx;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = data_q[0];

   always_comb begin
      data_d  = data_q;
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      wr_idx  = do_pop ? (count_q - CntW'(1)) : count_q;
      if (do_pop) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            data_d[i] = data_q[i + 1];
         end
         data_d[DEPTH-1] = '0;
      end
      if (do_push) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (CntW'(i) == wr_idx) begin
               data_d[i] = wdata_i;
            end
         end
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/mac_out_packer.sv
// Writeback stage: requantises MAC results, packs PACK lanes per word and queues masked writes.
module mac_out_packer
   import mac_out_packer_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned PACK       = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  cfg_start,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic                  cfg_relu_en,
   output logic                  busy,
   mac_out_packer_if.slave       bus
);

   localparam int unsigned LaneW  = $clog2(PACK);
   localparam int unsigned DataW  = PACK * OUT_WIDTH;
   localparam int unsigned EntryW = ADDR_WIDTH + PACK + DataW;
   localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

   state_t                state_q, state_d;
   logic [LaneW-1:0]      lane_q, lane_d;
   logic [DataW-1:0]      pack_q, pack_d, word_merged;
   logic [PACK-1:0]       mask_q, mask_d, mask_merged;
   logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d, base_q, base_d;
   logic                  relu_q, relu_d;
   logic [OUT_WIDTH-1:0]  lane_val;
   logic                  accept, complete, start;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CntW-1:0]       fifo_count;
   logic [EntryW-1:0]     push_entry, head_entry;

   assign start    = (state_q == StIdle) && cfg_start;
   assign accept   = bus.in_valid && bus.in_ready;
   assign complete = accept && ((lane_q == LaneW'(PACK - 1)) || bus.in_last);
   assign lane_val = OUT_WIDTH'(sat_relu(64'(signed'(bus.in_data)), OUT_WIDTH, relu_q));

   // Current sample merged into the partial word, so a completing sample is pushed this cycle.
   always_comb begin
      word_merged = pack_q;
      mask_merged = mask_q;
      for (int k = 0; k < int'(PACK); k++) begin
         if (lane_q == LaneW'(k)) begin
            word_merged[k*OUT_WIDTH +: OUT_WIDTH] = lane_val;
            mask_merged[k] = 1'b1;
         end
      end
   end

   always_comb begin
      base_d     = base_q;
      relu_d     = relu_q;
      word_cnt_d = word_cnt_q;
      lane_d     = lane_q;
      pack_d     = pack_q;
      mask_d     = mask_q;
      if (start) begin
         base_d     = cfg_base_addr;
         relu_d     = cfg_relu_en;
         word_cnt_d = '0;
         lane_d     = '0;
         pack_d     = '0;
         mask_d     = '0;
      end else if (complete) begin
         word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
         lane_d     = '0;
         pack_d     = '0;
         mask_d     = '0;
      end else if (accept) begin
         lane_d = lane_q + LaneW'(1);
         pack_d = word_merged;
         mask_d = mask_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         base_q     <= '0;
         relu_q     <= 1'b0;
         word_cnt_q <= '0;
         lane_q     <= '0;
         pack_q     <= '0;
         mask_q     <= '0;
      end else begin
         base_q     <= base_d;
         relu_q     <= relu_d;
         word_cnt_q <= word_cnt_d;
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         mask_q     <= mask_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cfg_start) state_d = StRun;
         StRun:   if (accept && bus.in_last) state_d = StDrain;
         StDrain: if (fifo_empty) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy         = (state_q != StIdle);
      bus.in_ready = (state_q == StRun) && (fifo_count < CntW'(FIFO_DEPTH));
   end

   assign push_entry = {base_q + word_cnt_q, mask_merged, word_merged};
   assign fifo_push  = complete && !fifo_full;
   assign fifo_pop   = !fifo_empty && bus.mem_ready;

   word_fifo #(
      .WIDTH (EntryW),
      .DEPTH (FIFO_DEPTH)
   ) u_word_fifo (
      .clk_i   (clk),
      .rst_ni  (arst_n_in),
      .push_i  (fifo_push),
      .wdata_i (push_entry),
      .pop_i   (fifo_pop),
      .rdata_o (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign bus.mem_valid = !fifo_empty;
   assign bus.mem_addr  = head_entry[EntryW-1 -: ADDR_WIDTH];
   assign bus.mem_wmask = head_entry[DataW +: PACK];
   assign bus.mem_wdata = head_entry[DataW-1:0];

endmodule
